// File: rtl/tlb_cp0_ctrl_if.sv
// Pipeline and TLB-facing signal bundle for the CP0 TLB controller.
// The controller uses the slave view. The pipeline/TLB environment uses the master view.
interface tlb_cp0_ctrl_if;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic        op_tlbwi;
    logic        op_tlbwr;
    logic        op_tlbp;
    logic        op_tlbr;
    logic        busy;
    logic [83:0] tlb_config;
    logic        tlbwi;
    logic        tlbp;
    logic [31:0] tlbp_result;
    logic [3:0]  tlb_rd_index;
    logic [83:0] tlb_rd_data;
    logic        tlb_exp;
    logic [31:0] tlb_exp_vaddr;
    logic [7:0]  asid;

    modport slave (
        input  mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
        input  op_tlbwi, op_tlbwr, op_tlbp, op_tlbr,
        input  tlbp_result, tlb_rd_data, tlb_exp, tlb_exp_vaddr,
        output mfc0_data, busy, tlb_config, tlbwi, tlbp, tlb_rd_index, asid
    );

    modport master (
        output mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
        output op_tlbwi, op_tlbwr, op_tlbp, op_tlbr,
        output tlbp_result, tlb_rd_data, tlb_exp, tlb_exp_vaddr,
        input  mfc0_data, busy, tlb_config, tlbwi, tlbp, tlb_rd_index, asid
    );
endinterface

// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB management registers and the TLBWI/TLBWR/TLBP/TLBR sequencer.
// Each TLB operation occupies one extra cycle. Register reads are combinational.
module tlb_cp0_ctrl (
    input  logic           clk,
    input  logic           rst,
    tlb_cp0_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PROBE, S_READ} state_t;

    localparam logic [4:0] A_INDEX    = 5'd0;
    localparam logic [4:0] A_RANDOM   = 5'd1;
    localparam logic [4:0] A_LO0      = 5'd2;
    localparam logic [4:0] A_LO1      = 5'd3;
    localparam logic [4:0] A_WIRED    = 5'd6;
    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_HI       = 5'd10;

    state_t      state_q;
    logic        tlbwi_q, tlbp_q;
    logic [83:0] tlb_config_q;
    logic [3:0]  rd_idx_q;

    logic        index_p_q,  index_p_d;
    logic [3:0]  index_q,    index_d;
    logic [3:0]  random_q,   random_d;
    logic [3:0]  wired_q,    wired_d;
    logic [23:0] lo0_pfn_q,  lo0_pfn_d;
    logic        lo0_d_q,    lo0_d_d;
    logic        lo0_v_q,    lo0_v_d;
    logic        lo0_g_q,    lo0_g_d;
    logic [23:0] lo1_pfn_q,  lo1_pfn_d;
    logic        lo1_d_q,    lo1_d_d;
    logic        lo1_v_q,    lo1_v_d;
    logic        lo1_g_q,    lo1_g_d;
    logic [18:0] hi_vpn2_q,  hi_vpn2_d;
    logic [7:0]  hi_asid_q,  hi_asid_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic idle, acc_write, acc_wr, acc_probe, acc_read;
    logic wr_index, wr_lo0, wr_lo1, wr_wired, wr_hi;
    logic [83:0] write_cfg;

    // Fields of the entry returned by the TLB for TLBR (its index field is not used).
    logic [18:0] rd_vpn2;
    logic [7:0]  rd_asid;
    logic        rd_g;
    logic [23:0] rd_pfn1, rd_pfn0;
    logic        rd_d1, rd_v1, rd_d0, rd_v0;
    logic        unused_bits;

    assign rd_vpn2 = bus.tlb_rd_data[79:61];
    assign rd_asid = bus.tlb_rd_data[60:53];
    assign rd_g    = bus.tlb_rd_data[52];
    assign rd_pfn1 = bus.tlb_rd_data[51:28];
    assign rd_d1   = bus.tlb_rd_data[27];
    assign rd_v1   = bus.tlb_rd_data[26];
    assign rd_pfn0 = bus.tlb_rd_data[25:2];
    assign rd_d0   = bus.tlb_rd_data[1];
    assign rd_v0   = bus.tlb_rd_data[0];
    assign unused_bits = &{1'b0, bus.tlb_rd_data[83:80], bus.tlbp_result[30:4]};

    // Ops are only taken in IDLE; simultaneous requests resolve wi > wr > p > r.
    assign idle      = (state_q == S_IDLE);
    assign acc_write = idle & (bus.op_tlbwi | bus.op_tlbwr);
    assign acc_wr    = idle & ~bus.op_tlbwi & bus.op_tlbwr;
    assign acc_probe = idle & ~bus.op_tlbwi & ~bus.op_tlbwr & bus.op_tlbp;
    assign acc_read  = idle & ~bus.op_tlbwi & ~bus.op_tlbwr & ~bus.op_tlbp & bus.op_tlbr;

    assign wr_index = bus.mtc0_we & (bus.mtc0_addr == A_INDEX);
    assign wr_lo0   = bus.mtc0_we & (bus.mtc0_addr == A_LO0);
    assign wr_lo1   = bus.mtc0_we & (bus.mtc0_addr == A_LO1);
    assign wr_wired = bus.mtc0_we & (bus.mtc0_addr == A_WIRED);
    assign wr_hi    = bus.mtc0_we & (bus.mtc0_addr == A_HI);

    // Write payload built from current (pre-mtc0) register values.
    assign write_cfg = {acc_wr ? random_q : index_q, hi_vpn2_q, hi_asid_q,
                        lo0_g_q & lo1_g_q,
                        lo1_pfn_q, lo1_d_q, lo1_v_q,
                        lo0_pfn_q, lo0_d_q, lo0_v_q};

    // Sequencer: one cycle in WRITE/PROBE/READ, strobes registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tlbwi_q      <= 1'b0;
            tlbp_q       <= 1'b0;
            tlb_config_q <= '0;
            rd_idx_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tlbwi_q <= 1'b0;
                    tlbp_q  <= 1'b0;
                    if (acc_write) begin
                        state_q      <= S_WRITE;
                        tlbwi_q      <= 1'b1;
                        tlb_config_q <= write_cfg;
                    end else if (acc_probe) begin
                        state_q <= S_PROBE;
                        tlbp_q  <= 1'b1;
                    end else if (acc_read) begin
                        state_q  <= S_READ;
                        rd_idx_q <= index_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tlbwi_q <= 1'b0;
                    tlbp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Register next-state: MMU exception beats op completion, which beats mtc0.
    always_comb begin
        index_p_d  = index_p_q;
        index_d    = index_q;
        wired_d    = wired_q;
        lo0_pfn_d  = lo0_pfn_q;
        lo0_d_d    = lo0_d_q;
        lo0_v_d    = lo0_v_q;
        lo0_g_d    = lo0_g_q;
        lo1_pfn_d  = lo1_pfn_q;
        lo1_d_d    = lo1_d_q;
        lo1_v_d    = lo1_v_q;
        lo1_g_d    = lo1_g_q;
        hi_vpn2_d  = hi_vpn2_q;
        hi_asid_d  = hi_asid_q;
        badvaddr_d = badvaddr_q;

        if (wr_wired)
            random_d = 4'd15;
        else if (random_q <= wired_q)
            random_d = 4'd15;
        else
            random_d = random_q - 4'd1;

        if (wr_wired)
            wired_d = bus.mtc0_data[3:0];

        if (state_q == S_PROBE) begin
            index_p_d = bus.tlbp_result[31];
            index_d   = bus.tlbp_result[3:0];
        end else if (wr_index) begin
            index_d = bus.mtc0_data[3:0];
        end

        if (state_q == S_READ) begin
            lo0_pfn_d = rd_pfn0;
            lo0_d_d   = rd_d0;
            lo0_v_d   = rd_v0;
            lo0_g_d   = rd_g;
            lo1_pfn_d = rd_pfn1;
            lo1_d_d   = rd_d1;
            lo1_v_d   = rd_v1;
            lo1_g_d   = rd_g;
        end else begin
            if (wr_lo0) begin
                lo0_pfn_d = bus.mtc0_data[29:6];
                lo0_d_d   = bus.mtc0_data[2];
                lo0_v_d   = bus.mtc0_data[1];
                lo0_g_d   = bus.mtc0_data[0];
            end
            if (wr_lo1) begin
                lo1_pfn_d = bus.mtc0_data[29:6];
                lo1_d_d   = bus.mtc0_data[2];
                lo1_v_d   = bus.mtc0_data[1];
                lo1_g_d   = bus.mtc0_data[0];
            end
        end

        // An MMU exception owns EntryHi for the cycle; ASID is left as it was.
        if (bus.tlb_exp) begin
            hi_vpn2_d  = bus.tlb_exp_vaddr[31:13];
            badvaddr_d = bus.tlb_exp_vaddr;
        end else if (state_q == S_READ) begin
            hi_vpn2_d = rd_vpn2;
            hi_asid_d = rd_asid;
        end else if (wr_hi) begin
            hi_vpn2_d = bus.mtc0_data[31:13];
            hi_asid_d = bus.mtc0_data[7:0];
        end
    end

    // CP0 register state; reset also clears data so software sees a defined TLB image.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_p_q  <= 1'b0;
            index_q    <= '0;
            random_q   <= 4'd15;
            wired_q    <= '0;
            lo0_pfn_q  <= '0;
            lo0_d_q    <= 1'b0;
            lo0_v_q    <= 1'b0;
            lo0_g_q    <= 1'b0;
            lo1_pfn_q  <= '0;
            lo1_d_q    <= 1'b0;
            lo1_v_q    <= 1'b0;
            lo1_g_q    <= 1'b0;
            hi_vpn2_q  <= '0;
            hi_asid_q  <= '0;
            badvaddr_q <= '0;
        end else begin
            index_p_q  <= index_p_d;
            index_q    <= index_d;
            random_q   <= random_d;
            wired_q    <= wired_d;
            lo0_pfn_q  <= lo0_pfn_d;
            lo0_d_q    <= lo0_d_d;
            lo0_v_q    <= lo0_v_d;
            lo0_g_q    <= lo0_g_d;
            lo1_pfn_q  <= lo1_pfn_d;
            lo1_d_q    <= lo1_d_d;
            lo1_v_q    <= lo1_v_d;
            lo1_g_q    <= lo1_g_d;
            hi_vpn2_q  <= hi_vpn2_d;
            hi_asid_q  <= hi_asid_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Combinational CP0 read; unimplemented addresses and bits read as zero.
    always_comb begin
        bus.mfc0_data = '0;
        case (bus.mfc0_addr)
            A_INDEX:    bus.mfc0_data = {index_p_q, 27'b0, index_q};
            A_RANDOM:   bus.mfc0_data = {28'b0, random_q};
            A_LO0:      bus.mfc0_data = {2'b0, lo0_pfn_q, 3'b0, lo0_d_q, lo0_v_q, lo0_g_q};
            A_LO1:      bus.mfc0_data = {2'b0, lo1_pfn_q, 3'b0, lo1_d_q, lo1_v_q, lo1_g_q};
            A_WIRED:    bus.mfc0_data = {28'b0, wired_q};
            A_BADVADDR: bus.mfc0_data = badvaddr_q;
            A_HI:       bus.mfc0_data = {hi_vpn2_q, 5'b0, hi_asid_q};
            default:    bus.mfc0_data = '0;
        endcase
    end

    assign bus.busy         = ~idle;
    assign bus.tlbwi        = tlbwi_q;
    assign bus.tlbp         = tlbp_q;
    assign bus.tlb_config   = tlb_config_q;
    assign bus.tlb_rd_index = (state_q == S_READ) ? rd_idx_q : index_q;
    assign bus.asid         = hi_asid_q;
endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Scoreboard bench for tlb_cp0_ctrl: directed scenarios followed by random traffic,
// compared against an architectural model of the CP0 registers.
module tb_tlb_cp0_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tlb_cp0_ctrl_if bus();

    tlb_cp0_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam int P_IDLE  = 0;
    localparam int P_WRITE = 1;
    localparam int P_PROBE = 2;
    localparam int P_READ  = 3;

    // Architectural model: registers as software sees them (32-bit views).
    logic [31:0] m_index, m_lo0, m_lo1, m_hi, m_badv;
    logic [3:0]  m_random, m_wired, m_rdidx;
    logic [83:0] m_cfg;
    int          m_pend;

    typedef struct {
        logic [31:0] mfc0;
        logic        busy;
        logic        tlbwi;
        logic        tlbp;
        logic [3:0]  rdidx;
        logic [7:0]  asid;
        logic [83:0] cfg;
    } obs_t;

    obs_t        obs_q[$];
    logic [83:0] strobe_q[$];
    obs_t        mon_o;
    logic [83:0] mon_cfg;
    bit          live = 1'b0;
    bit          done = 1'b0;
    bit          final_done = 1'b0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0:    return m_index;
            5'd1:    return {28'b0, m_random};
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd6:    return {28'b0, m_wired};
            5'd8:    return m_badv;
            5'd10:   return m_hi;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [83:0] m_pack(input logic [3:0] idx);
        return {idx, m_hi[31:13], m_hi[7:0], m_lo0[0] & m_lo1[0],
                m_lo1[29:6], m_lo1[2], m_lo1[1],
                m_lo0[29:6], m_lo0[2], m_lo0[1]};
    endfunction

    task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_obs();
        obs_t o;
        o.mfc0  = m_read(bus.mfc0_addr);
        o.busy  = (m_pend != P_IDLE);
        o.tlbwi = (m_pend == P_WRITE);
        o.tlbp  = (m_pend == P_PROBE);
        o.rdidx = (m_pend == P_READ) ? m_rdidx : m_index[3:0];
        o.asid  = m_hi[7:0];
        o.cfg   = m_cfg;
        obs_q.push_back(o);
    endtask

    // Advance the model by one clock edge using the inputs applied this cycle.
    task automatic step();
        logic [31:0] n_index, n_lo0, n_lo1, n_hi, n_badv;
        logic [3:0]  n_random, n_wired, n_rdidx;
        logic [83:0] n_cfg, r;
        logic [31:0] d;
        logic [4:0]  a;
        logic        we;
        int          n_pend;
        if (rst) begin
            m_index = 0; m_lo0 = 0; m_lo1 = 0; m_hi = 0; m_badv = 0;
            m_random = 4'd15; m_wired = 0; m_rdidx = 0; m_cfg = 0; m_pend = P_IDLE;
            return;
        end
        n_index = m_index; n_lo0 = m_lo0; n_lo1 = m_lo1; n_hi = m_hi; n_badv = m_badv;
        n_wired = m_wired; n_rdidx = m_rdidx; n_cfg = m_cfg; n_pend = P_IDLE;
        we = bus.mtc0_we; a = bus.mtc0_addr; d = bus.mtc0_data; r = bus.tlb_rd_data;

        if (we && a == 5'd6)           n_random = 4'd15;
        else if (m_random <= m_wired)  n_random = 4'd15;
        else                           n_random = m_random - 4'd1;
        if (we && a == 5'd6) n_wired = d[3:0];

        if (m_pend == P_IDLE) begin
            if (bus.op_tlbwi || bus.op_tlbwr) begin
                n_cfg = m_pack(bus.op_tlbwi ? m_index[3:0] : m_random);
                strobe_q.push_back(n_cfg);
                n_pend = P_WRITE;
            end else if (bus.op_tlbp) begin
                n_pend = P_PROBE;
            end else if (bus.op_tlbr) begin
                n_pend  = P_READ;
                n_rdidx = m_index[3:0];
            end
        end

        if (m_pend == P_PROBE)
            n_index = {bus.tlbp_result[31], 27'b0, bus.tlbp_result[3:0]};
        else if (we && a == 5'd0)
            n_index = {m_index[31], 27'b0, d[3:0]};

        if (m_pend == P_READ) begin
            n_lo0 = {2'b0, r[25:2], 3'b0, r[1], r[0], r[52]};
            n_lo1 = {2'b0, r[51:28], 3'b0, r[27], r[26], r[52]};
        end else begin
            if (we && a == 5'd2) n_lo0 = d & 32'h3FFF_FFC7;
            if (we && a == 5'd3) n_lo1 = d & 32'h3FFF_FFC7;
        end

        if (bus.tlb_exp) begin
            n_hi   = {bus.tlb_exp_vaddr[31:13], 5'b0, m_hi[7:0]};
            n_badv = bus.tlb_exp_vaddr;
        end else if (m_pend == P_READ) begin
            n_hi = {r[79:61], 5'b0, r[60:53]};
        end else if (we && a == 5'd10) begin
            n_hi = d & 32'hFFFF_E0FF;
        end

        m_index = n_index; m_lo0 = n_lo0; m_lo1 = n_lo1; m_hi = n_hi; m_badv = n_badv;
        m_random = n_random; m_wired = n_wired; m_rdidx = n_rdidx; m_cfg = n_cfg; m_pend = n_pend;
    endtask

    task automatic tick();
        if (live) push_obs();
        @(posedge clk);
        step();
        #1;
        bus.mtc0_we = 1'b0;
        bus.op_tlbwi = 1'b0; bus.op_tlbwr = 1'b0; bus.op_tlbp = 1'b0; bus.op_tlbr = 1'b0;
        bus.tlb_exp = 1'b0;
        rst = 1'b0;
        live = 1'b1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.mtc0_we = 1'b1; bus.mtc0_addr = a; bus.mtc0_data = d;
        tick();
    endtask

    // Monitor: checks every observed cycle and each tlbwi strobe payload.
    always @(negedge clk) begin
        if (obs_q.size() > 0) begin
            mon_o = obs_q.pop_front();
            chk("mfc0_data",    {52'b0, bus.mfc0_data},   {52'b0, mon_o.mfc0});
            chk("busy",         {83'b0, bus.busy},        {83'b0, mon_o.busy});
            chk("tlbwi",        {83'b0, bus.tlbwi},       {83'b0, mon_o.tlbwi});
            chk("tlbp",         {83'b0, bus.tlbp},        {83'b0, mon_o.tlbp});
            chk("tlb_rd_index", {80'b0, bus.tlb_rd_index},{80'b0, mon_o.rdidx});
            chk("asid",         {76'b0, bus.asid},        {76'b0, mon_o.asid});
            chk("tlb_config",   bus.tlb_config,           mon_o.cfg);
        end
        if (bus.tlbwi === 1'b1) begin
            if (strobe_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tlbwi_unexpected: actual=1 expected=0 at %0t", $time);
            end else begin
                mon_cfg = strobe_q.pop_front();
                chk("tlbwi_payload", bus.tlb_config, mon_cfg);
            end
        end
        if (done && !final_done) begin
            final_done = 1'b1;
            chk("strobes_drained", 84'(strobe_q.size()), 84'd0);
        end
    end

    logic [4:0]  addrs [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd8, 5'd10, 5'd4};
    logic [95:0] rnd96;

    initial begin
        rst = 1'b1;
        bus.mtc0_we = 0; bus.mtc0_addr = 0; bus.mtc0_data = 0; bus.mfc0_addr = 0;
        bus.op_tlbwi = 0; bus.op_tlbwr = 0; bus.op_tlbp = 0; bus.op_tlbr = 0;
        bus.tlbp_result = 0; bus.tlb_rd_data = 0; bus.tlb_exp = 0; bus.tlb_exp_vaddr = 0;
        tick();
        rst = 1'b1; tick();
        repeat (2) tick();

        // TLBWI with a known entry
        mtc0(5'd0, 32'd5);
        mtc0(5'd10, 32'h0040_20A3);
        mtc0(5'd2, 32'h40);
        mtc0(5'd3, 32'h47);
        bus.op_tlbwi = 1'b1; tick();
        repeat (3) tick();

        // Random walk against Wired
        rst = 1'b1; tick();
        bus.mfc0_addr = 5'd1;
        mtc0(5'd6, 32'd3);
        repeat (20) tick();
        mtc0(5'd6, 32'd15);
        repeat (5) tick();
        mtc0(5'd6, 32'd0);

        // TLBP hit and miss
        bus.mfc0_addr = 5'd0;
        bus.tlbp_result = 32'h8000_0000; bus.op_tlbp = 1'b1; tick();
        repeat (3) tick();
        bus.tlbp_result = 32'h0000_0007; bus.op_tlbp = 1'b1; tick();
        repeat (3) tick();

        // TLBR from index 9
        mtc0(5'd0, 32'd9);
        bus.tlb_rd_data = {4'h0, 19'h12345, 8'h11, 1'b1, 24'hABCDE, 1'b1, 1'b1,
                           24'h13579, 1'b0, 1'b1};
        bus.mfc0_addr = 5'd10;
        bus.op_tlbr = 1'b1; tick();
        repeat (3) tick();
        bus.mfc0_addr = 5'd2; tick();
        bus.mfc0_addr = 5'd3; tick();

        // MMU exception colliding with an EntryHi write
        bus.mfc0_addr = 5'd10;
        bus.tlb_exp = 1'b1; bus.tlb_exp_vaddr = 32'h7FFF_E123;
        mtc0(5'd10, 32'h0);
        tick();
        bus.mfc0_addr = 5'd8; tick();

        // Op accepted together with an Index write, then an op ignored while busy
        bus.op_tlbwi = 1'b1; mtc0(5'd0, 32'd2);
        bus.op_tlbp = 1'b1; tick();
        repeat (2) tick();
        bus.op_tlbwr = 1'b1; tick();
        repeat (2) tick();

        // Reset during WRITE
        bus.op_tlbwi = 1'b1; tick();
        rst = 1'b1; tick();
        bus.mfc0_addr = 5'd1;
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int op;
            bus.mfc0_addr = addrs[$urandom_range(0, 8)];
            bus.mtc0_we   = ($urandom_range(0, 2) == 0);
            bus.mtc0_addr = addrs[$urandom_range(0, 8)];
            bus.mtc0_data = $urandom;
            op = $urandom_range(0, 7);
            bus.op_tlbwi = (op == 0);
            bus.op_tlbwr = (op == 1);
            bus.op_tlbp  = (op == 2);
            bus.op_tlbr  = (op == 3);
            bus.tlbp_result = $urandom;
            rnd96 = {$urandom, $urandom, $urandom};
            bus.tlb_rd_data = rnd96[83:0];
            bus.tlb_exp = ($urandom_range(0, 15) == 0);
            bus.tlb_exp_vaddr = $urandom;
            rst = ($urandom_range(0, 127) == 0);
            tick();
        end
        repeat (3) tick();

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tlb_cp0_ctrl.md
TLB_CP0_CTRL -- requirements
Module: tlb_cp0_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, system clock; rst in 1, synchronous active-high reset; no other clock or reset.
REQ-002 SHALL have ports: mtc0_we in 1; mtc0_addr in 5; mtc0_data in 32: CP0 register write from the pipeline.
REQ-003 SHALL have ports: mfc0_addr in 5; mfc0_data out 32: combinational CP0 register read.
REQ-004 SHALL have ports: op_tlbwi, op_tlbwr, op_tlbp, op_tlbr in 1 each: one-hot instruction requests, 1-cycle pulses.
REQ-005 SHALL have port busy out 1: high while an operation is in flight; upstream stalls.
REQ-006 SHALL have ports to the TLB: tlb_config out 84, write payload; tlbwi out 1, write strobe; tlbp out 1, probe strobe; tlbp_result in 32; tlb_rd_index out 4; tlb_rd_data in 84.
REQ-007 SHALL have ports: tlb_exp in 1, TLB miss/invalid/dirty from the MMU; tlb_exp_vaddr in 32; asid out 8 = EntryHi[7:0].
REQ-008 SHALL pack tlb_config/tlb_rd_data as [83:80] index, [79:61] VPN2, [60:53] ASID, [52] G, [51:28] PFN1, [27] D1, [26] V1, [25:2] PFN0, [1] D0, [0] V0; tlb_rd_data index field ignored.
REQ-009 SHALL interpret tlbp_result as bit31 = not-found (P), [3:0] = matching index, other bits ignored.

Function
REQ-010 SHALL implement CP0 registers at addresses: Index 0, Random 1, EntryLo0 2, EntryLo1 3, PageMask 5, Wired 6, BadVAddr 8, EntryHi 10; other addresses read 0, writes ignored.
REQ-011 SHALL store only: Index {P[31], idx[3:0]}; EntryLo {PFN[29:6], D[2], V[1], G[0]}; EntryHi {VPN2[31:13], ASID[7:0]}; Wired [3:0]; Random [3:0]; unimplemented bits read 0.
REQ-012 SHALL treat Index.P, Random, BadVAddr, PageMask (reads 0) as not software-writable.
REQ-013 SHALL update Random each cycle: if Random <= Wired, load 15; else decrement by 1; Wired = 15 holds Random at 15.
REQ-014 SHALL load Random = 15 on any mtc0 write to Wired, overriding the REQ-013 update that cycle.
REQ-015 SHALL use FSM states IDLE, WRITE, PROBE, READ; busy = (state != IDLE).
REQ-016 SHALL accept ops only in IDLE; ops while busy are ignored; each non-IDLE state lasts exactly 1 cycle, then returns to IDLE.
REQ-017 On op_tlbwi/op_tlbwr accepted in cycle N, SHALL register tlb_config at the end of N from current EntryHi/EntryLo0/EntryLo1, index = Index[3:0] (wi) or Random (wr), G = Lo0.G & Lo1.G; tlbwi high only in N+1 (WRITE).
REQ-018 SHALL hold tlb_config between writes.
REQ-019 On op_tlbp accepted in N, SHALL assert tlbp only in N+1 (PROBE) and, at end of N+1, load Index = {tlbp_result[31], 27'b0, tlbp_result[3:0]}.
REQ-020 On op_tlbr accepted in N, SHALL drive tlb_rd_index = Index[3:0] in N+1 (READ) and, at end of N+1, load EntryHi, EntryLo0, EntryLo1 from tlb_rd_data; both EntryLo G bits = field G.
REQ-021 SHALL make updated registers visible on mfc0_data from cycle N+2 (PROBE/READ).
REQ-022 SHALL drive tlb_rd_index = Index[3:0] outside READ.
REQ-023 On tlb_exp, SHALL load BadVAddr = tlb_exp_vaddr and EntryHi[31:13] = tlb_exp_vaddr[31:13], keeping ASID, regardless of FSM state.
REQ-024 SHALL apply register-update priority, highest first: tlb_exp, PROBE/READ completion, mtc0 write.
REQ-025 SHALL, when an op is accepted in the same cycle as an mtc0 write, capture pre-write register values; the write still applies.

Reset
REQ-026 SHALL, on rst high at a clock edge, set state IDLE, Random 15, all other registers 0, tlbwi/tlbp/busy 0, tlb_config 0.
REQ-027 SHALL, on reset mid-operation, abandon the operation with no TLB strobe or register update in the following cycle.

Verification
REQ-028 Write Index=5, EntryHi=0x00402_0A3, Lo0=0x40, Lo1=0x47, then op_tlbwi -> one tlbwi pulse next cycle; tlb_config index 5, VPN2 0x00201, ASID 0xA3, G 0, PFN0 1, PFN1 1, D1 1, V1 1.
REQ-029 Wired=3 after reset -> Random reads 15, 14, ..., 3, 15 on successive cycles; with Wired=15, Random stays 15.
REQ-030 op_tlbp with tlbp_result=0x80000000 -> Index reads 0x80000000 two cycles later; with 0x00000007 -> Index reads 0x7.
REQ-031 op_tlbr at Index=9, tlb_rd_data ASID 0x11, G 1 -> tlb_rd_index 9 in READ; EntryHi ASID 0x11, both Lo G = 1; asid output 0x11.
REQ-032 tlb_exp with vaddr 0x7FFF_E123 in the same cycle as an mtc0 write of EntryHi=0 -> BadVAddr 0x7FFFE123, EntryHi[31:13] 0x3FFFF, ASID unchanged.
REQ-033 op_tlbwi then rst asserted during WRITE -> tlbwi low next cycle, busy 0, Random 15.
